// File: rtl/mem_burst_regfile.sv
// Parametrised register-file memory for the SPI slave datapath, with a clear sweep,
// an auto-incrementing burst pointer and registered read-valid / error strobes.
module mem_burst_regfile #(
    parameter int unsigned           DATA_W   = 8,
    parameter int unsigned           ADDR_W   = 4,
    parameter logic [DATA_W-1:0]     INIT_VAL = '0,
    parameter logic [DATA_W-1:0]     CLR_TAG  = DATA_W'('h11)
) (
    input  logic              mem_clk,
    input  logic              mem_rst,
    input  logic              mem_en,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic              mem_burst,
    input  logic              mem_we,
    input  logic              mem_re,
    input  logic [DATA_W-1:0] buffer_rx,
    output logic [DATA_W-1:0] buffer_tx,
    output logic              mem_rvalid,
    input  logic              mem_initial,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   eff_addr;
    logic                req;
    logic                accept;
    logic                do_write;
    logic                do_read;
    logic                sweep_we;
    logic                reject;

    always_comb begin
        eff_addr = mem_burst ? ptr : mem_address;
        req      = mem_en & (mem_we | mem_re);
        accept   = (state == IDLE) & req & ~mem_initial;
        do_write = accept & mem_we;
        do_read  = accept & mem_re & ~mem_we;
        sweep_we = (state == CLEAR) & ~mem_initial;
        // Busy/clear-start drops the access; we+re together still writes but flags the lost read.
        reject   = (req & ((state == CLEAR) | mem_initial)) | (accept & mem_we & mem_re);
    end

    assign mem_busy = (state == CLEAR);

    always_ff @(posedge mem_clk) begin
        if (sweep_we) begin
            mem[ptr] <= INIT_VAL;
        end else if (do_write) begin
            mem[eff_addr] <= buffer_rx;
        end
    end

    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            state      <= CLEAR;
            ptr        <= '0;
            buffer_tx  <= '0;
            mem_rvalid <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            mem_rvalid <= do_read;
            mem_err    <= reject;
            if (mem_initial) begin
                state     <= CLEAR;
                ptr       <= '0;
                buffer_tx <= CLR_TAG;
            end else begin
                case (state)
                    CLEAR: begin
                        ptr <= ptr + 1'b1;
                        if (ptr == '1) begin
                            state <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (accept) begin
                            ptr <= eff_addr + 1'b1;
                        end
                        if (do_read) begin
                            buffer_tx <= mem[eff_addr];
                        end
                    end
                    default: state <= CLEAR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_burst_regfile.sv
// Scoreboard bench for mem_burst_regfile: stimulus queues expected read data / error pulses,
// a negedge monitor pops and compares them whenever the DUT strobes mem_rvalid or mem_err.
module tb_mem_burst_regfile;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, burst = 1'b0, we = 1'b0, re = 1'b0, ini = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] rx = '0;
    logic [7:0] tx;
    logic       rvalid, busy, err;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   failed = 0;

    mem_burst_regfile #(.DATA_W(8), .ADDR_W(4), .INIT_VAL(8'h00), .CLR_TAG(8'h11)) dut (
        .mem_clk(clk), .mem_rst(rst), .mem_en(en), .mem_address(addr), .mem_burst(burst),
        .mem_we(we), .mem_re(re), .buffer_rx(rx), .buffer_tx(tx), .mem_rvalid(rvalid),
        .mem_initial(ini), .mem_busy(busy), .mem_err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the next queued expectation, in order.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rvalid) begin
                if (q.size() == 0) begin
                    check("unexpected_rvalid", 32'(rvalid), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("rvalid_kind", 32'(e.is_err), 32'd0);
                    if (!e.is_err) check("read_data", 32'(tx), 32'(e.data));
                end
            end
            if (err) begin
                if (q.size() == 0) begin
                    check("unexpected_err", 32'(err), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("err_kind", 32'(e.is_err), 32'd1);
                end
            end
        end
    end

    // One clock of stimulus: apply just after a rising edge, hold through the next one.
    task automatic access(input logic e, input logic w, input logic r, input logic b,
                          input logic i, input logic [3:0] a, input logic [7:0] d);
        en = e; we = w; re = r; burst = b; ini = i; addr = a; rx = d;
        @(posedge clk);
        #1;
        en = 1'b0; we = 1'b0; re = 1'b0; burst = 1'b0; ini = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic b, input logic [7:0] d);
        access(1'b1, 1'b1, 1'b0, b, 1'b0, a, d);
    endtask

    task automatic rd(input logic [3:0] a, input logic b, input logic [7:0] expd);
        q.push_back('{is_err: 1'b0, data: expd});
        access(1'b1, 1'b0, 1'b1, b, 1'b0, a, 8'h00);
    endtask

    task automatic expect_err();
        q.push_back('{is_err: 1'b1, data: 8'h00});
    endtask

    task automatic count_busy(input string name, input int exp);
        int n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        check(name, 32'(n), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic read_all_zero();
        for (int unsigned k = 0; k < 16; k++) rd(4'(k), 1'b0, 8'h00);
    endtask

    initial begin
        // 1: reset state, 16-cycle sweep, memory cleared
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'h00);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        count_busy("busy_after_reset", 16);
        read_all_zero();

        // 2: write then back-to-back read at the same address
        wr(4'd3, 1'b0, 8'hA5);
        rd(4'd3, 1'b0, 8'hA5);

        // 3: seeded burst with wrap 15 -> 0 -> 1
        wr(4'd14, 1'b0, 8'hEE);
        wr(4'd0, 1'b1, 8'h01);
        wr(4'd0, 1'b1, 8'h02);
        wr(4'd0, 1'b1, 8'h03);
        rd(4'd15, 1'b0, 8'h01);
        rd(4'd0, 1'b1, 8'h02);
        rd(4'd0, 1'b1, 8'h03);
        rd(4'd14, 1'b0, 8'hEE);
        rd(4'd3, 1'b0, 8'hA5);

        // 5: write and read together: write wins, error pulse, no rvalid
        expect_err();
        access(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 8'h3C);
        rd(4'd5, 1'b0, 8'h3C);

        // enable low: request ignored, no error
        access(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 8'h77);
        rd(4'd5, 1'b0, 8'h3C);

        // 4: clear command, tag on buffer_tx, write during sweep rejected
        access(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        check("clr_tag", 32'(tx), 32'h11);
        expect_err();
        wr(4'd0, 1'b0, 8'hFF);
        count_busy("busy_after_clear", 15);
        check("clr_tag_hold", 32'(tx), 32'h11);
        read_all_zero();

        // 6: reset in the middle of a sweep
        wr(4'd9, 1'b0, 8'h5A);
        access(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        repeat (6) @(posedge clk);
        #1;
        check("mid_sweep_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_tx", 32'(tx), 32'h00);
        check("async_rst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_busy("busy_after_midreset", 16);
        rd(4'd9, 1'b0, 8'h00);
        rd(4'd15, 1'b0, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
